// File: rtl/i2c_sniff_pkg.sv
// Shared types for the I2C sniff UART send/receive sequencers:
// record-assembly state encoding, byte-index constants and the record struct.
package i2c_sniff_pkg;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_REG  = 2'd1,
        S_DATA = 2'd2
    } seq_state_e;

    localparam int BYTE_ADDR = 0;
    localparam int BYTE_REG  = 1;
    localparam int BYTE_DATA = 2;
    localparam int REC_BYTES = 3;

    typedef struct packed {
        logic [7:0] address;
        logic [7:0] reg_address;
        logic [7:0] reg_data;
    } i2c_rec_t;

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Saturating idle timer: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES is reached.
module uart_rx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 100_000,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] count;
    logic          at_limit;

    assign at_limit = (count == TW'(TIMEOUT_CYCLES));
    assign expired  = enable & at_limit;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && !at_limit)
            count <= count + TW'(1);
    end

endmodule

// File: rtl/uart_recv_sequencer.sv
// Regroups UART RX bytes into {address, reg_address, reg_data} records with a
// one-deep output slot; drops partial records on timeout or framing error.
module uart_recv_sequencer
    import i2c_sniff_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_frame_err,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [7:0]       address,
    output logic [7:0]       reg_address,
    output logic [7:0]       reg_data,
    output logic             timeout_err,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] record_count
);

    seq_state_e state, state_nxt;
    i2c_rec_t   rec;
    logic [7:0] stage_addr, stage_reg;

    logic good_byte, bad_byte, tmr_expired, tmr_clear, tmr_en;
    logic cap_addr, cap_reg, rec_done, slot_free, rec_load;
    logic ovf_set, to_set, fe_set, stage_clr, handshake;

    assign good_byte = rx_valid & ~rx_frame_err;
    assign bad_byte  = rx_valid & rx_frame_err;
    assign handshake = rec_valid & rec_ready;

    // Any byte restarts the timer, so a byte arriving on the expiry cycle wins.
    assign tmr_en    = (state == S_REG) || (state == S_DATA);
    assign tmr_clear = rx_valid | ~tmr_en;

    uart_rx_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_ADDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ADDR:  if (good_byte) state_nxt = S_REG;
            S_REG:   if (bad_byte || (!rx_valid && tmr_expired)) state_nxt = S_ADDR;
                     else if (good_byte)                         state_nxt = S_DATA;
            S_DATA:  if (rx_valid || tmr_expired) state_nxt = S_ADDR;
            default: state_nxt = S_ADDR;
        endcase
    end

    always_comb begin
        cap_addr  = good_byte && (state == S_ADDR);
        cap_reg   = good_byte && (state == S_REG);
        rec_done  = good_byte && (state == S_DATA);
        slot_free = ~rec_valid | rec_ready;
        rec_load  = rec_done & slot_free;
        ovf_set   = rec_done & ~slot_free;
        to_set    = ~rx_valid & tmr_expired;
        fe_set    = bad_byte;
        stage_clr = (bad_byte && (state != S_ADDR)) || to_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_addr   <= '0;
            stage_reg    <= '0;
            rec          <= '0;
            rec_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            frame_err    <= 1'b0;
            overflow     <= 1'b0;
            record_count <= '0;
        end else begin
            timeout_err <= to_set;
            frame_err   <= fe_set;
            overflow    <= ovf_set;

            if (stage_clr) begin
                stage_addr <= '0;
                stage_reg  <= '0;
            end else begin
                if (cap_addr) stage_addr <= rx_data;
                if (cap_reg)  stage_reg  <= rx_data;
            end

            // A load on the handshake cycle keeps the slot full with the new record.
            if (rec_load) begin
                rec.address     <= stage_addr;
                rec.reg_address <= stage_reg;
                rec.reg_data    <= rx_data;
                rec_valid       <= 1'b1;
            end else if (handshake) begin
                rec_valid <= 1'b0;
            end

            if (handshake) record_count <= record_count + CNT_W'(1);
        end
    end

    assign address     = rec.address;
    assign reg_address = rec.reg_address;
    assign reg_data    = rec.reg_data;

endmodule

// File: tb/tb_uart_recv_sequencer.sv
// Directed bench for uart_recv_sequencer: record assembly, timeout, framing
// error, overflow, same-cycle handshake and mid-record reset.
module tb_uart_recv_sequencer;
    import i2c_sniff_pkg::*;

    localparam int T     = 40;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_valid, rx_frame_err, rec_ready;
    logic [7:0]       rx_data;
    logic             rec_valid, timeout_err, frame_err, overflow;
    logic [7:0]       address, reg_address, reg_data;
    logic [CNT_W-1:0] record_count;

    int n_chk = 0, n_fail = 0;
    int n_to = 0, n_fe = 0, n_ovf = 0, n_multi = 0;
    int exp_cnt = 0;
    int s_to, s_fe, s_ovf;

    uart_recv_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_frame_err(rx_frame_err), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .address(address), .reg_address(reg_address), .reg_data(reg_data),
        .timeout_err(timeout_err), .frame_err(frame_err), .overflow(overflow),
        .record_count(record_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timeout_err) n_to++;
        if (frame_err)   n_fe++;
        if (overflow)    n_ovf++;
        if (int'(timeout_err) + int'(frame_err) + int'(overflow) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; rx_frame_err = fe;
        @(negedge clk);
        rx_valid = 1'b0; rx_frame_err = 1'b0;
    endtask

    task automatic snap();
        s_to = n_to; s_fe = n_fe; s_ovf = n_ovf;
    endtask

    // Called right after the third byte: record must already be valid.
    task automatic expect_rec(input string tag, input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
        check({tag, "_valid"}, 32'(rec_valid), 32'd1);
        check({tag, "_rec"}, {8'h0, address, reg_address, reg_data}, {8'h0, a, r, d});
        if (rec_ready) begin
            exp_cnt++;
            @(negedge clk);
            check({tag, "_cnt"}, 32'(record_count), 32'(exp_cnt));
            check({tag, "_clr"}, 32'(rec_valid), 32'd0);
        end
    endtask

    task automatic send_rec(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
        send_byte(a, 1'b0);
        send_byte(r, 1'b0);
        send_byte(d, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_frame_err = 1'b0; rec_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_rec", {8'h0, address, reg_address, reg_data}, 32'h0);
        check("rst_cnt", 32'(record_count), 32'd0);
        check("rst_state", 32'(dut.state), 32'(S_ADDR));

        // basic record with 20-cycle gaps
        send_byte(8'h50, 1'b0); repeat (20) @(negedge clk);
        send_byte(8'h10, 1'b0); repeat (20) @(negedge clk);
        check("basic_pre", 32'(rec_valid), 32'd0);
        send_byte(8'hA5, 1'b0);
        expect_rec("basic", 8'h50, 8'h10, 8'hA5);

        // timeout drops partial record
        snap();
        send_byte(8'h50, 1'b0); send_byte(8'h10, 1'b0);
        repeat (T + 5) @(negedge clk);
        check("to_pulse", 32'(n_to - s_to), 32'd1);
        check("to_state", 32'(dut.state), 32'(S_ADDR));
        check("to_valid", 32'(rec_valid), 32'd0);
        send_rec(8'h51, 8'h20, 8'h33);
        expect_rec("to_next", 8'h51, 8'h20, 8'h33);

        // byte on the expiry cycle wins
        snap();
        send_byte(8'h60, 1'b0);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        expect_rec("edge", 8'h60, 8'h61, 8'h62);
        @(negedge clk);
        check("edge_no_to", 32'(n_to - s_to), 32'd0);

        // framing error mid-record
        snap();
        send_byte(8'h50, 1'b0);
        send_byte(8'h10, 1'b1);
        @(negedge clk);
        check("fe_pulse", 32'(n_fe - s_fe), 32'd1);
        check("fe_state", 32'(dut.state), 32'(S_ADDR));
        send_rec(8'h77, 8'h88, 8'h99);
        expect_rec("fe_next", 8'h77, 8'h88, 8'h99);

        // overflow with consumer stalled
        snap();
        rec_ready = 1'b0;
        send_rec(8'h11, 8'h22, 8'h33);
        expect_rec("ovf_first", 8'h11, 8'h22, 8'h33);
        send_rec(8'h44, 8'h55, 8'h66);
        @(negedge clk);
        check("ovf_pulse", 32'(n_ovf - s_ovf), 32'd1);
        check("ovf_hold", {8'h0, address, reg_address, reg_data}, 32'h00112233);
        check("ovf_valid", 32'(rec_valid), 32'd1);
        check("ovf_cnt_hold", 32'(record_count), 32'(exp_cnt));
        rec_ready = 1'b1;
        exp_cnt++;
        @(negedge clk);
        check("ovf_cnt", 32'(record_count), 32'(exp_cnt));
        check("ovf_drain", 32'(rec_valid), 32'd0);

        // completion on the same cycle as the previous handshake
        snap();
        rec_ready = 1'b0;
        send_rec(8'hAA, 8'hBB, 8'hCC);
        expect_rec("same_first", 8'hAA, 8'hBB, 8'hCC);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b0);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'hFF; rec_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        exp_cnt++;
        check("same_cnt", 32'(record_count), 32'(exp_cnt));
        expect_rec("same", 8'hDD, 8'hEE, 8'hFF);
        @(negedge clk);
        check("same_no_ovf", 32'(n_ovf - s_ovf), 32'd0);

        // reset in the middle of a record
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_cnt = 0;
        check("mrst_valid", 32'(rec_valid), 32'd0);
        check("mrst_rec", {8'h0, address, reg_address, reg_data}, 32'h0);
        check("mrst_cnt", 32'(record_count), 32'd0);
        check("mrst_state", 32'(dut.state), 32'(S_ADDR));
        check("mrst_pulses", {29'h0, timeout_err, frame_err, overflow}, 32'h0);
        send_rec(8'h70, 8'h01, 8'h02);
        expect_rec("mrst_next", 8'h70, 8'h01, 8'h02);

        @(negedge clk);
        check("pulse_excl", 32'(n_multi), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
